video_mode_seq: RTL and testbench

Input-timing supervisor and sequencer for the scanconverter/syncgen datapath, running in the PCLK_in domain. It consumes the latched HSYNC/VSYNC and measures line period and lines per frame, then qualifies a mode as stable over several frames. It drives the syncgen reset release and the v_change event, and publishes the measured totals to the CPU PIO.

---
 rtl/cps2_digiav_pkg.sv | 20 ++
 rtl/sync_period_meter.sv | 62 ++++++
 rtl/video_mode_seq.sv | 167 ++++++++++++++++
 tb/tb_video_mode_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cps2_digiav_pkg.sv
// Shared definitions for the CPS2 digital AV input path.
// Holds the video mode sequencer state encoding, default counter widths and
// the nominal CPS2 line/frame totals.
package cps2_digiav_pkg;

  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;

  // Nominal CPS2 timing: pixel clocks per line, lines per frame.
  localparam int CPS2_HTOTAL = 512;
  localparam int CPS2_VTOTAL = 262;

  typedef enum logic [1:0] {
    S_NOSIG   = 2'd0,
    S_ACQUIRE = 2'd1,
    S_HOLDOFF = 2'd2,
    S_LOCKED  = 2'd3
  } vm_state_t;

endpackage

// File: rtl/sync_period_meter.sv
// Falling-edge detector plus saturating period counter for one sync input.
// Used for H (tick every clock) and for V (tick on each HSYNC edge).
//
// Ports:
//   PCLK_in  in   pixel clock
//   reset_n  in   async active-low reset
//   sync_in  in   sync input, active low
//   tick     in   count enable
//   fall     out  sync falling edge (registered value 1, input 0)
//   period   out  period of the interval that just ended: the value being
//                 latched in a fall cycle, otherwise the last latched one
//   sat      out  counter sits at all-ones
module sync_period_meter #(
  parameter int W           = 12,
  // 0: the tick in a fall cycle closes the old period (H, counts clocks).
  // 1: the tick in a fall cycle opens the new period (V, counts lines).
  parameter bit TICK_TO_NEW = 1'b0
) (
  input  logic         PCLK_in,
  input  logic         reset_n,
  input  logic         sync_in,
  input  logic         tick,
  output logic         fall,
  output logic [W-1:0] period,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic         sync_q;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] last;
  logic [W-1:0] meas;
  logic [W-1:0] cnt_restart;

  assign fall        = sync_q & ~sync_in;
  assign sat         = (cnt == CNT_MAX);
  assign cnt_inc     = sat ? cnt : cnt + CNT_ONE;
  assign meas        = (tick && !TICK_TO_NEW) ? cnt_inc : cnt;
  assign cnt_restart = (tick && TICK_TO_NEW) ? CNT_ONE : '0;
  // Forwarded so the frame compare sees this frame's value in the edge cycle.
  assign period      = fall ? meas : last;

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      cnt    <= '0;
      last   <= '0;
    end else begin
      sync_q <= sync_in;
      if (fall) begin
        last <= meas;
        cnt  <= cnt_restart;
      end else if (tick) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/video_mode_seq.sv
// Input-timing supervisor: measures line period and lines per frame from the
// latched syncs, qualifies a mode over several matching frames, holds the
// syncgen in reset for a few more frames, then releases it.
//
// Ports:
//   PCLK_in       in   pixel clock
//   reset_n       in   async active-low reset
//   enable        in   low forces S_NOSIG
//   HSYNC_in      in   latched HSYNC, active low
//   VSYNC_in      in   latched VSYNC, active low
//   hpix_total    out  qualified clocks per line
//   vlines_total  out  qualified lines per frame
//   locked        out  mode qualified (S_HOLDOFF or S_LOCKED)
//   sg_reset_n    out  syncgen reset, high only in S_LOCKED
//   v_change      out  one-cycle pulse when a locked mode is lost
//
// state     | meaning
// S_NOSIG   | no usable input, waiting for a VSYNC edge
// S_ACQUIRE | counting consecutive matching frames
// S_HOLDOFF | mode qualified, syncgen still held in reset
// S_LOCKED  | mode qualified, syncgen running
module video_mode_seq
  import cps2_digiav_pkg::*;
#(
  parameter int HCNT_W         = HCNT_W_DEF,
  parameter int VCNT_W         = VCNT_W_DEF,
  parameter int STABLE_FRAMES  = 3,
  parameter int HOLDOFF_FRAMES = 2,
  parameter int HTOL           = 2
) (
  input  logic              PCLK_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              HSYNC_in,
  input  logic              VSYNC_in,
  output logic [HCNT_W-1:0] hpix_total,
  output logic [VCNT_W-1:0] vlines_total,
  output logic              locked,
  output logic              sg_reset_n,
  output logic              v_change
);

  localparam logic [3:0]      STABLE_C = 4'(STABLE_FRAMES);
  localparam logic [3:0]      HOLD_C   = 4'(HOLDOFF_FRAMES);
  localparam logic [HCNT_W:0] HTOL_C   = (HCNT_W+1)'(HTOL);

  logic              hs_fall, vs_fall, h_timeout, v_timeout;
  logic [HCNT_W-1:0] h_meas;
  logic [VCNT_W-1:0] v_meas;

  sync_period_meter #(.W(HCNT_W), .TICK_TO_NEW(1'b0)) u_hmeter (
    .PCLK_in (PCLK_in),
    .reset_n (reset_n),
    .sync_in (HSYNC_in),
    .tick    (1'b1),
    .fall    (hs_fall),
    .period  (h_meas),
    .sat     (h_timeout)
  );

  sync_period_meter #(.W(VCNT_W), .TICK_TO_NEW(1'b1)) u_vmeter (
    .PCLK_in (PCLK_in),
    .reset_n (reset_n),
    .sync_in (VSYNC_in),
    .tick    (hs_fall),
    .fall    (vs_fall),
    .period  (v_meas),
    .sat     (v_timeout)
  );

  vm_state_t         state, state_nxt;
  logic [3:0]        cnt, cnt_nxt, cnt_inc;
  logic [HCNT_W-1:0] cand_h, cand_h_nxt, tot_h_nxt;
  logic [VCNT_W-1:0] cand_v, cand_v_nxt, tot_v_nxt;
  logic [HCNT_W:0]   dh;
  logic              match, vchg_nxt;

  // One extra bit so the difference never wraps.
  assign dh      = (h_meas >= cand_h) ? ({1'b0, h_meas} - {1'b0, cand_h})
                                      : ({1'b0, cand_h} - {1'b0, h_meas});
  assign match   = (dh <= HTOL_C) && (v_meas == cand_v);
  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_h_nxt = cand_h;
    cand_v_nxt = cand_v;
    tot_h_nxt  = hpix_total;
    tot_v_nxt  = vlines_total;
    vchg_nxt   = 1'b0;
    if (h_timeout || v_timeout || !enable) begin
      state_nxt  = S_NOSIG;
      cnt_nxt    = '0;
      cand_h_nxt = '0;
      cand_v_nxt = '0;
      vchg_nxt   = (state == S_LOCKED);
    end else if (vs_fall) begin
      if (!match) begin
        cand_h_nxt = h_meas;
        cand_v_nxt = v_meas;
      end
      case (state)
        S_NOSIG: begin
          state_nxt = S_ACQUIRE;
          cnt_nxt   = '0;
        end
        S_ACQUIRE: begin
          if (!match) begin
            cnt_nxt = '0;
          end else if (cnt_inc == STABLE_C) begin
            tot_h_nxt = cand_h;
            tot_v_nxt = cand_v;
            cnt_nxt   = '0;
            state_nxt = (HOLDOFF_FRAMES == 0) ? S_LOCKED : S_HOLDOFF;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_HOLDOFF: begin
          if (!match) begin
            state_nxt = S_ACQUIRE;
            cnt_nxt   = '0;
          end else if (cnt_inc == HOLD_C) begin
            state_nxt = S_LOCKED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_LOCKED: begin
          if (!match) begin
            state_nxt = S_ACQUIRE;
            cnt_nxt   = '0;
            vchg_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_NOSIG;
      endcase
    end
  end

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_NOSIG;
      cnt          <= '0;
      cand_h       <= '0;
      cand_v       <= '0;
      hpix_total   <= '0;
      vlines_total <= '0;
      locked       <= 1'b0;
      sg_reset_n   <= 1'b0;
      v_change     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cand_h       <= cand_h_nxt;
      cand_v       <= cand_v_nxt;
      hpix_total   <= tot_h_nxt;
      vlines_total <= tot_v_nxt;
      locked       <= (state_nxt == S_HOLDOFF) || (state_nxt == S_LOCKED);
      sg_reset_n   <= (state_nxt == S_LOCKED);
      v_change     <= vchg_nxt;
    end
  end

endmodule

// File: tb/tb_video_mode_seq.sv
// Directed bench for video_mode_seq. Frames are shortened to 64 clocks per
// line and 16 lines per frame to keep run time small; HSYNC and VSYNC fall
// in the same clock at every frame start.
module tb_video_mode_seq;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;
  localparam int LINE   = 64;
  localparam int LINES  = 16;
  localparam int HS_LOW = 4;

  logic              PCLK_in = 1'b0;
  logic              reset_n, enable, HSYNC_in, VSYNC_in;
  logic [HCNT_W-1:0] hpix_total;
  logic [VCNT_W-1:0] vlines_total;
  logic              locked, sg_reset_n, v_change;

  int n_tests  = 0;
  int n_fail   = 0;
  int vchg_cnt = 0;

  typedef struct {
    string tag;
    logic  lk;
    logic  sg;
    logic  vc;
    int    h;
    int    v;
  } exp_t;

  exp_t sb[$];

  video_mode_seq #(
    .HCNT_W(HCNT_W), .VCNT_W(VCNT_W), .STABLE_FRAMES(3),
    .HOLDOFF_FRAMES(2), .HTOL(2)
  ) dut (
    .PCLK_in      (PCLK_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .HSYNC_in     (HSYNC_in),
    .VSYNC_in     (VSYNC_in),
    .hpix_total   (hpix_total),
    .vlines_total (vlines_total),
    .locked       (locked),
    .sg_reset_n   (sg_reset_n),
    .v_change     (v_change)
  );

  always #5 PCLK_in = ~PCLK_in;

  always @(negedge PCLK_in) if (v_change === 1'b1) vchg_cnt <= vchg_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic lk, input logic sg,
                              input logic vc, input int h, input int v);
    exp_t e;
    e.tag = tag; e.lk = lk; e.sg = sg; e.vc = vc; e.h = h; e.v = v;
    return e;
  endfunction

  task automatic sb_pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".locked"}, 32'(locked), 32'(e.lk));
      chk({e.tag, ".sg_reset_n"}, 32'(sg_reset_n), 32'(e.sg));
      chk({e.tag, ".v_change"}, 32'(v_change), 32'(e.vc));
      chk({e.tag, ".hpix_total"}, 32'(hpix_total), e.h);
      chk({e.tag, ".vlines_total"}, 32'(vlines_total), e.v);
    end
  endtask

  // One frame; e is the expected state one clock after its leading vs_fall.
  // dis_line >= 0 drops enable at that line and restores it one line later.
  task automatic send_frame(input string tag, input int nl, input int p0, input int p1,
                            input bit vs_en, input exp_t e, input int dis_line);
    int p;
    if (vs_en) sb.push_back(e);
    for (int l = 0; l < nl; l++) begin
      p = (l % 2 == 0) ? p0 : p1;
      for (int c = 0; c < p; c++) begin
        HSYNC_in = (c < HS_LOW) ? 1'b0 : 1'b1;
        VSYNC_in = (vs_en && l < 2) ? 1'b0 : 1'b1;
        if (l == dis_line && c == 0) begin
          enable = 1'b0;
          sb.push_back(mk({tag, "_dis"}, 1'b0, 1'b0, 1'b0, LINE, LINES));
        end
        if (l == dis_line + 1 && c == 0) enable = 1'b1;
        @(posedge PCLK_in); #1;
        if (vs_en && l == 0 && c == 0) sb_pop_check();
        if (l == dis_line && c == 0) sb_pop_check();
      end
    end
  endtask

  // Acquire sequence from an unlocked start: three frames unqualified,
  // qualified (HOLDOFF) at the fourth edge, syncgen released at the sixth.
  task automatic lock_frames(input string tag, input int n, input int pre_h,
                             input int pre_v, input int dis_frame);
    logic lk, sg;
    for (int i = 0; i < n; i++) begin
      lk = (i >= 3);
      sg = (i == 5);
      send_frame($sformatf("%s_f%0d", tag, i), LINES, LINE, LINE, 1'b1,
                 mk($sformatf("%s_f%0d", tag, i), lk, sg, 1'b0,
                    lk ? LINE : pre_h, lk ? LINES : pre_v),
                 (i == dis_frame) ? 5 : -1);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    repeat (3) @(posedge PCLK_in);
    #1;
    sb.push_back(mk("reset", 1'b0, 1'b0, 1'b0, 0, 0));
    sb_pop_check();
    #2 reset_n = 1'b1;
    repeat (4) @(posedge PCLK_in);
    #1;

    // Full frame of lines before the first VSYNC so frame 1 is measured fully.
    send_frame("pre", LINES, LINE, LINE, 1'b0, mk("pre", 1'b0, 1'b0, 1'b0, 0, 0), -1);
    lock_frames("lock", 6, 0, 0, -1);
    chk("vchg_cnt_lock", vchg_cnt, 0);

    // One frame one line too long while locked.
    send_frame("long_start", LINES + 1, LINE, LINE, 1'b1,
               mk("long_start", 1'b1, 1'b1, 1'b0, LINE, LINES), -1);
    send_frame("long_end", LINES, LINE, LINE, 1'b1,
               mk("long_end", 1'b0, 1'b0, 1'b1, LINE, LINES), -1);
    chk("vchg_cnt_long", vchg_cnt, 1);
    lock_frames("relock1", 6, LINE, LINES, -1);

    // Line period jitter: +/-1 and +2 tolerated, +3 loses lock.
    send_frame("jit_pm1", LINES, LINE - 1, LINE + 1, 1'b1,
               mk("jit_pm1", 1'b1, 1'b1, 1'b0, LINE, LINES), -1);
    send_frame("jit_p2", LINES, LINE + 2, LINE + 2, 1'b1,
               mk("jit_p2", 1'b1, 1'b1, 1'b0, LINE, LINES), -1);
    send_frame("jit_p3", LINES, LINE + 3, LINE + 3, 1'b1,
               mk("jit_p3", 1'b1, 1'b1, 1'b0, LINE, LINES), -1);
    chk("vchg_cnt_jit_ok", vchg_cnt, 1);
    send_frame("jit_lost", LINES, LINE, LINE, 1'b1,
               mk("jit_lost", 1'b0, 1'b0, 1'b1, LINE, LINES), -1);
    chk("vchg_cnt_jit_lost", vchg_cnt, 2);
    lock_frames("relock2", 6, LINE, LINES, -1);

    // HSYNC stuck high: line counter saturates and the mode is dropped.
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    sb.push_back(mk("stuck_early", 1'b1, 1'b1, 1'b0, LINE, LINES));
    repeat (3900) @(posedge PCLK_in);
    #1;
    sb_pop_check();
    sb.push_back(mk("stuck_late", 1'b0, 1'b0, 1'b0, LINE, LINES));
    repeat (300) @(posedge PCLK_in);
    #1;
    sb_pop_check();
    chk("vchg_cnt_stuck", vchg_cnt, 3);

    // Restart: first edge still sees the saturated counter, then reacquire and
    // drop enable in the middle of HOLDOFF.
    send_frame("resume_to", LINES, LINE, LINE, 1'b1,
               mk("resume_to", 1'b0, 1'b0, 1'b0, LINE, LINES), -1);
    lock_frames("hold_dis", 4, LINE, LINES, 3);
    lock_frames("relock3", 6, LINE, LINES, -1);
    chk("vchg_cnt_dis", vchg_cnt, 3);

    // Async reset while locked.
    repeat (10) @(posedge PCLK_in);
    #1;
    sb.push_back(mk("pre_areset", 1'b1, 1'b1, 1'b0, LINE, LINES));
    sb_pop_check();
    @(posedge PCLK_in);
    #3 reset_n = 1'b0;
    #1;
    sb.push_back(mk("areset", 1'b0, 1'b0, 1'b0, 0, 0));
    sb_pop_check();
    #10 reset_n = 1'b1;
    repeat (3) @(posedge PCLK_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
